// File: rtl/alu32.sv
// Single-cycle registered ALU: AND/OR/ADD/ANDN/ORN/SUB/SLT with zero and
// signed-overflow flags, one result per accepted cycle, no backpressure.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ControlALU,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_RSVD = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    add_ovf = (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    sub_ovf = (sa != sb) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic signed [WIDTH-1:0] diff_p0;
  logic                    add_ovf_p0;
  logic                    sub_ovf_p0;
  logic                    slt_p0;
  logic        [WIDTH-1:0] res_p0;
  logic                    ovf_p0;
  logic                    vld_p0;

  logic        [WIDTH-1:0] y_p1;
  logic                    zero_p1;
  logic                    ovf_p1;
  logic                    vld_p1;

  // ---- stage p0: combinational operation decode ----
  assign a_p0    = signed'(a);
  assign b_p0    = signed'(b);
  assign vld_p0  = in_valid;
  assign sum_p0  = a_p0 + b_p0;
  assign diff_p0 = a_p0 - b_p0;

  assign add_ovf_p0 = add_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sum_p0[WIDTH-1]);
  assign sub_ovf_p0 = sub_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], diff_p0[WIDTH-1]);
  // Overflow flips the apparent sign of the difference, so fold it back in.
  assign slt_p0     = diff_p0[WIDTH-1] ^ sub_ovf_p0;

  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    unique case (ControlALU)
      OP_AND:  res_p0 = a & b;
      OP_OR:   res_p0 = a | b;
      OP_ADD: begin
        res_p0 = unsigned'(sum_p0);
        ovf_p0 = add_ovf_p0;
      end
      OP_RSVD: res_p0 = '0;
      OP_ANDN: res_p0 = a & ~b;
      OP_ORN:  res_p0 = a | ~b;
      OP_SUB: begin
        res_p0 = unsigned'(diff_p0);
        ovf_p0 = sub_ovf_p0;
      end
      OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, slt_p0};
      default: res_p0 = '0;
    endcase
  end

  // ---- stage p1: result register; holds when no operation is accepted ----
  always_ff @(posedge clk) begin
    if (reset) begin
      y_p1    <= '0;
      zero_p1 <= 1'b1;
      ovf_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        y_p1    <= res_p0;
        zero_p1 <= (res_p0 == '0);
        ovf_p1  <= ovf_p0;
      end
    end
  end

  assign y         = y_p1;
  assign zero      = zero_p1;
  assign overflow  = ovf_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32: per-feature tasks with inline checks.
module tb_alu32;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ControlALU;
  logic        in_valid;
  logic [31:0] y;
  logic        zero;
  logic        overflow;
  logic        out_valid;

  int tests = 0;
  int fails = 0;

  alu32 #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
    .ControlALU(ControlALU),
    .in_valid(in_valid),
    .y(y),
    .zero(zero),
    .overflow(overflow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic apply(input logic rst, input logic vld, input logic [2:0] op,
                       input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    reset      = rst;
    in_valid   = vld;
    ControlALU = op;
    a          = av;
    b          = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 3'b010, 32'd7, 32'd9);
    tests++;
    if (y !== 32'd0) begin fails++; $display("FAIL reset_y: got %h want %h", y, 32'd0); end
    tests++;
    if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero: got %b want 1", zero); end
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", out_valid); end
    apply(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_vld: got %b want 0", out_valid); end
  endtask

  task automatic test_basic_ops();
    apply(1'b0, 1'b1, 3'b010, 32'd1, 32'd2);
    tests++;
    if (y !== 32'd3 || zero !== 1'b0 || out_valid !== 1'b1)
      begin fails++; $display("FAIL add: y=%h z=%b v=%b want y=3 z=0 v=1", y, zero, out_valid); end
    apply(1'b0, 1'b1, 3'b000, 32'd1, 32'd2);
    tests++;
    if (y !== 32'd0 || zero !== 1'b1)
      begin fails++; $display("FAIL and: y=%h z=%b want y=0 z=1", y, zero); end
    apply(1'b0, 1'b1, 3'b001, 32'd1, 32'd2);
    tests++;
    if (y !== 32'd3 || zero !== 1'b0)
      begin fails++; $display("FAIL or: y=%h z=%b want y=3 z=0", y, zero); end
    apply(1'b0, 1'b1, 3'b100, 32'd1, 32'd2);
    tests++;
    if (y !== 32'd1) begin fails++; $display("FAIL andn: y=%h want 1", y); end
    apply(1'b0, 1'b1, 3'b101, 32'd1, 32'd2);
    tests++;
    if (y !== 32'hFFFF_FFFD) begin fails++; $display("FAIL orn: y=%h want fffffffd", y); end
    apply(1'b0, 1'b1, 3'b110, 32'd1, 32'd2);
    tests++;
    if (y !== 32'hFFFF_FFFF || zero !== 1'b0 || overflow !== 1'b0)
      begin fails++; $display("FAIL sub: y=%h z=%b o=%b want y=ffffffff z=0 o=0", y, zero, overflow); end
    apply(1'b0, 1'b1, 3'b111, 32'd1, 32'd2);
    tests++;
    if (y !== 32'd1 || zero !== 1'b0)
      begin fails++; $display("FAIL slt: y=%h z=%b want y=1 z=0", y, zero); end
  endtask

  task automatic test_overflow();
    apply(1'b0, 1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1);
    tests++;
    if (y !== 32'h8000_0000 || overflow !== 1'b1)
      begin fails++; $display("FAIL add_ovf: y=%h o=%b want y=80000000 o=1", y, overflow); end
    apply(1'b0, 1'b1, 3'b110, 32'h8000_0000, 32'd1);
    tests++;
    if (y !== 32'h7FFF_FFFF || overflow !== 1'b1)
      begin fails++; $display("FAIL sub_ovf: y=%h o=%b want y=7fffffff o=1", y, overflow); end
    apply(1'b0, 1'b1, 3'b001, 32'h8000_0000, 32'd1);
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL or_no_ovf: o=%b want 0", overflow); end
  endtask

  task automatic test_slt();
    apply(1'b0, 1'b1, 3'b111, 32'h8000_0000, 32'd1);
    tests++;
    if (y !== 32'd1 || overflow !== 1'b0)
      begin fails++; $display("FAIL slt_min: y=%h o=%b want y=1 o=0", y, overflow); end
    apply(1'b0, 1'b1, 3'b111, 32'd1, 32'h8000_0000);
    tests++;
    if (y !== 32'd0 || zero !== 1'b1)
      begin fails++; $display("FAIL slt_pos_min: y=%h z=%b want y=0 z=1", y, zero); end
    apply(1'b0, 1'b1, 3'b111, 32'd5, 32'd5);
    tests++;
    if (y !== 32'd0 || zero !== 1'b1)
      begin fails++; $display("FAIL slt_eq: y=%h z=%b want y=0 z=1", y, zero); end
    apply(1'b0, 1'b1, 3'b111, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    tests++;
    if (y !== 32'd1) begin fails++; $display("FAIL slt_neg: y=%h want 1", y); end
  endtask

  task automatic test_hold();
    apply(1'b0, 1'b1, 3'b010, 32'd3, 32'd4);
    tests++;
    if (y !== 32'd7 || out_valid !== 1'b1)
      begin fails++; $display("FAIL hold_load: y=%h v=%b want y=7 v=1", y, out_valid); end
    apply(1'b0, 1'b0, 3'b010, 32'd100, 32'd200);
    tests++;
    if (y !== 32'd7 || out_valid !== 1'b0 || zero !== 1'b0)
      begin fails++; $display("FAIL hold_1: y=%h v=%b z=%b want y=7 v=0 z=0", y, out_valid, zero); end
    apply(1'b0, 1'b0, 3'b110, 32'd0, 32'd0);
    tests++;
    if (y !== 32'd7 || out_valid !== 1'b0)
      begin fails++; $display("FAIL hold_2: y=%h v=%b want y=7 v=0", y, out_valid); end
  endtask

  task automatic test_reset_midstream();
    apply(1'b0, 1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1);
    apply(1'b1, 1'b1, 3'b010, 32'd1, 32'd2);
    tests++;
    if (y !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0)
      begin fails++; $display("FAIL rst_mid: y=%h z=%b v=%b o=%b want y=0 z=1 v=0 o=0", y, zero, out_valid, overflow); end
    apply(1'b0, 1'b1, 3'b010, 32'd1, 32'd2);
    tests++;
    if (y !== 32'd3 || out_valid !== 1'b1)
      begin fails++; $display("FAIL rst_first: y=%h v=%b want y=3 v=1", y, out_valid); end
  endtask

  task automatic test_reserved_wrap();
    apply(1'b0, 1'b1, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    tests++;
    if (y !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b1)
      begin fails++; $display("FAIL rsvd: y=%h z=%b v=%b want y=0 z=1 v=1", y, zero, out_valid); end
    apply(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
    tests++;
    if (y !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0)
      begin fails++; $display("FAIL wrap: y=%h z=%b o=%b want y=0 z=1 o=0", y, zero, overflow); end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 3'b010, 32'd10, 32'd20);
    tests++;
    if (y !== 32'd30 || out_valid !== 1'b1)
      begin fails++; $display("FAIL b2b_0: y=%h v=%b want y=1e v=1", y, out_valid); end
    apply(1'b0, 1'b1, 3'b110, 32'd10, 32'd20);
    tests++;
    if (y !== 32'hFFFF_FFF6 || out_valid !== 1'b1)
      begin fails++; $display("FAIL b2b_1: y=%h v=%b want y=fffffff6 v=1", y, out_valid); end
    apply(1'b0, 1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tests++;
    if (y !== 32'hF000_F000 || out_valid !== 1'b1)
      begin fails++; $display("FAIL b2b_2: y=%h v=%b want y=f000f000 v=1", y, out_valid); end
    apply(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tests++;
    if (out_valid !== 1'b0 || y !== 32'hF000_F000)
      begin fails++; $display("FAIL b2b_end: y=%h v=%b want y=f000f000 v=0", y, out_valid); end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    ControlALU = 3'b000;
    a          = '0;
    b          = '0;
    test_reset();
    test_basic_ops();
    test_overflow();
    test_slt();
    test_hold();
    test_reset_midstream();
    test_reserved_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu32.md
ALU32 -- requirements
Module: alu32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data path width in bits; all values below assume 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-005 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-006 The block SHALL have port ControlALU, input, 3 bits: operation select.
REQ-007 The block SHALL have port in_valid, input, 1 bit: operands and ControlALU are valid this cycle.
REQ-008 The block SHALL have port y, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port zero, output, 1 bit: registered flag, 1 iff y == 0.
REQ-010 The block SHALL have port overflow, output, 1 bit: registered signed-overflow flag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: y/zero/overflow hold a result from the previous accepted cycle.

Function
REQ-012 The block SHALL decode ControlALU as follows, computing the result combinationally from a and b:
- 000: y = a AND b
- 001: y = a OR b
- 010: y = a + b, modulo 2^WIDTH
- 011: reserved; y = 0
- 100: y = a AND (NOT b)
- 101: y = a OR (NOT b)
- 110: y = a - b, modulo 2^WIDTH
- 111: SLT; y = 1 if a < b as two's-complement signed values, else 0
REQ-013 For op 111, the comparison SHALL be correct even when a - b overflows; the sign bit of (a - b) is XORed with the subtraction overflow.
REQ-014 The overflow flag SHALL be computed as follows:
- op 010: overflow = 1 when a and b have the same sign and the sum's sign differs from them.
- op 110: overflow = 1 when a and b have different signs and the difference's sign differs from a.
- All other ops: overflow = 0.
REQ-015 The zero flag SHALL be 1 iff the registered WIDTH-bit y is all zeros, for every op including reserved.
REQ-016 Latency SHALL be exactly 1 cycle: when in_valid = 1 at rising edge N, y, zero, overflow and out_valid = 1 SHALL reflect those inputs immediately after edge N.
REQ-017 When in_valid = 0 at an edge, the block SHALL hold y, zero and overflow at their previous values and drive out_valid = 0.
REQ-018 The block SHALL apply no backpressure; back-to-back in_valid produces one result per cycle.
REQ-019 Carries out of the MSB SHALL be discarded; no carry output is provided.

Reset
REQ-020 When reset = 1 at a rising edge, y SHALL be 0, zero SHALL be 1, overflow SHALL be 0 and out_valid SHALL be 0, regardless of in_valid.
REQ-021 Reset SHALL take priority over in_valid in the same cycle; the operation presented that cycle is discarded.
REQ-022 The first valid result SHALL appear one cycle after the first in_valid = 1 following reset deassertion.

Verification
REQ-023 With a = 1, b = 2 and in_valid = 1, the bench SHALL apply each op in turn and check the following one cycle later:
- 010 -> y = 3, zero = 0
- 000 -> y = 0, zero = 1
- 001 -> y = 3
- 100 -> y = 1
- 110 -> y = 0xFFFFFFFF, zero = 0
- 111 -> y = 1
REQ-024 Overflow: the bench SHALL check:
- a = 0x7FFFFFFF, b = 1, op 010 -> y = 0x80000000, overflow = 1
- a = 0x80000000, b = 1, op 110 -> y = 0x7FFFFFFF, overflow = 1
REQ-025 SLT signed and overflow cases: the bench SHALL check:
- a = 0x80000000, b = 1, op 111 -> y = 1
- a = 1, b = 0x80000000, op 111 -> y = 0
- a = 5, b = 5, op 111 -> y = 0, zero = 1
REQ-026 Hold: the bench SHALL compute 3 + 4 (op 010), then drop in_valid with new operands, and check y stays 7 and out_valid = 0.
REQ-027 Reset mid-stream: the bench SHALL assert reset together with in_valid = 1, a = 1, b = 2, op 010, and check y = 0, zero = 1, out_valid = 0 next cycle.
REQ-028 Reserved op and wrap-around: the bench SHALL check:
- op 011, any operands -> y = 0, zero = 1
- a = 0xFFFFFFFF, b = 1, op 010 -> y = 0, zero = 1, overflow = 0
